dino_player_ctrl: RTL and testbench
===================================

Name: dino_player_ctrl

Overview:
- Player vertical-motion controller: turns the jump button into the dino's per-frame vertical position.
- Drives the 6-bit y position consumed by the dino sprite renderer (its i_ypos input). Sits directly upstream of that renderer.
- Motion runs as a frame-stepped state machine with integer velocity and gravity. Updates happen only on the once-per-frame tick from the VGA timing block.

Parameters:
- GROUND_Y, 40, resting y (sprite top row, renderer units); must be ≤ 63 - MAX_FALL_VEL
- JUMP_VEL, 6, initial upward speed (rows/tick), 1..15
- GRAVITY, 1, speed change per tick, 1..JUMP_VEL
- MAX_FALL_VEL, 7, downward speed clamp, ≥ GRAVITY

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- i_frame_tick, input, 1, 1-clk strobe, once per frame (end of visible area)
- i_jump, input, 1, raw jump button level (asynchronous)
- i_game_over, input, 1, level; collision detected, freeze player
- i_restart, input, 1, 1-clk strobe; return to ground state
- o_ypos, output, 6, sprite top y (registered)
- o_airborne, output, 1, high in RISE/FALL (registered)
- o_land, output, 1, 1-clk pulse on the landing update (registered)

Behaviour:
- Reset (rst_n low, async):
  - state=GROUND, o_ypos=GROUND_Y, vel=0, sync flops=0, jump_req=0, o_airborne=0, o_land=0.
  - Reset mid-jump returns to ground immediately.
- Button path:
  - i_jump passes through a 2-flop synchronizer, then rising-edge detect.
  - jump_req sets 3 clks after the button edge. It stays set until consumed or cleared.
  - Held button does not re-trigger; a new rising edge is needed.
- States GROUND, RISE, FALL, DEAD. State changes only on i_frame_tick, except the DEAD/restart rules below.
- GROUND, tick with jump_req=1: vel←JUMP_VEL, state←RISE, jump_req←0, o_ypos unchanged.
- GROUND, tick with jump_req=0: no change.
- RISE, tick:
  - o_ypos←max(o_ypos−vel, 0), with saturation at 0 (no wrap).
  - If vel ≤ GRAVITY: vel←0, state←FALL. Otherwise vel←vel−GRAVITY.
- FALL, tick:
  - nxt = o_ypos+vel, computed 7-bit.
  - If nxt ≥ GROUND_Y: o_ypos←GROUND_Y, vel←0, state←GROUND, o_land=1 for that one clk.
  - Otherwise: o_ypos←nxt, vel←min(vel+GRAVITY, MAX_FALL_VEL).
- Position always uses the pre-update vel.
- Jump edge while in RISE/FALL sets jump_req; this is the buffered jump.
  - Consumed on the first GROUND tick after landing, i.e. the tick after the landing tick.
- Jump edge and tick in the same clk: the tick uses the old jump_req; the new request applies from the next tick.
- DEAD:
  - i_game_over=1 in any state: state←DEAD on the next clk, independent of tick. o_ypos and vel are frozen, jump_req←0, edges ignored.
  - o_airborne is 0 in DEAD.
- Restart:
  - i_restart in DEAD: state←GROUND, o_ypos←GROUND_Y, vel←0, jump_req←0 next clk.
  - i_restart outside DEAD is ignored.
- Priority: rst_n > i_game_over > i_restart > tick logic.
- o_ypos is always in [0, GROUND_Y]. o_airborne = (state==RISE || state==FALL), registered alongside state.

Test Plan:
1. Reset, then 5 ticks with no input → o_ypos=40, o_airborne=0, o_land=0 throughout.
2. Single jump, defaults, one button edge, then ticks T0..T13:
   - T0 takes off, RISE starts.
   - After ticks T1..T12, o_ypos = 34, 29, 25, 22, 20, 19(→FALL), 19, 20, 22, 25, 29, 34.
   - T13 → o_ypos=40, o_land pulses exactly 1 clk, o_airborne=0.
3. Buffered jump: second button edge at apex (~T6) → landing on T13, new RISE starts on T14, second arc identical to the first. A held button with no new edge → no second jump.
4. Ceiling clamp, JUMP_VEL=15, GROUND_Y=40: after ticks 1-4 o_ypos = 25, 11, 0, 0 (clamped, no wrap), then the descent continues normally and lands on 40.
5. i_game_over asserted mid-fall at o_ypos=22 → next clk state DEAD, o_ypos holds 22 over 10 ticks, jump edges ignored. i_restart strobe → o_ypos=40, GROUND.
6. rst_n dropped mid-RISE between ticks → o_ypos=40 asynchronously, o_airborne=0. After release the block stays grounded until a new jump edge.

Source files
------------

// File: rtl/dino_player_ctrl.sv
// Dino vertical-motion controller: turns the jump button into a per-frame sprite y position.
// State | meaning
// S_GROUND | resting at GROUND_Y, waiting for a jump request on a frame tick
// S_RISE   | moving up, speed decays by GRAVITY each tick
// S_FALL   | moving down, speed grows by GRAVITY up to MAX_FALL_VEL
// S_DEAD   | frozen after a collision until restart
module dino_player_ctrl #(
    parameter int GROUND_Y     = 40,
    parameter int JUMP_VEL     = 6,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL_VEL = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_tick,
    input  logic       i_jump,
    input  logic       i_game_over,
    input  logic       i_restart,
    output logic [5:0] o_ypos,
    output logic       o_airborne,
    output logic       o_land
);

    typedef enum logic [1:0] {S_GROUND, S_RISE, S_FALL, S_DEAD} state_t;

    localparam logic [5:0] GY  = 6'(GROUND_Y);
    localparam logic [3:0] JV  = 4'(JUMP_VEL);
    localparam logic [3:0] GR  = 4'(GRAVITY);
    localparam logic [3:0] MFV = 4'(MAX_FALL_VEL);

    state_t     state, state_nxt;
    logic [5:0] ypos_nxt;
    logic [3:0] vel, vel_nxt;
    logic       jump_req, jump_req_nxt;
    logic       land_nxt, airborne_nxt;
    logic       sync1, sync2, sync2_d;
    logic       jump_rise;
    logic [6:0] fall_sum;
    logic [4:0] vel_inc;

    assign jump_rise = sync2 & ~sync2_d;
    assign fall_sum  = {1'b0, o_ypos} + {3'b000, vel};
    assign vel_inc   = {1'b0, vel} + {1'b0, GR};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= i_jump;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    always_comb begin
        state_nxt    = state;
        ypos_nxt     = o_ypos;
        vel_nxt      = vel;
        jump_req_nxt = jump_req;
        land_nxt     = 1'b0;
        if (i_game_over) begin
            state_nxt    = S_DEAD;
            jump_req_nxt = 1'b0;
        end else if (state == S_DEAD) begin
            if (i_restart) begin
                state_nxt    = S_GROUND;
                ypos_nxt     = GY;
                vel_nxt      = 4'd0;
                jump_req_nxt = 1'b0;
            end
        end else begin
            if (i_frame_tick) begin
                case (state)
                    S_GROUND: begin
                        if (jump_req) begin
                            vel_nxt      = JV;
                            state_nxt    = S_RISE;
                            jump_req_nxt = 1'b0;
                        end
                    end
                    S_RISE: begin
                        // saturate at the top row instead of wrapping
                        ypos_nxt = ({2'b00, vel} > o_ypos) ? 6'd0 : o_ypos - {2'b00, vel};
                        if (vel <= GR) begin
                            vel_nxt   = 4'd0;
                            state_nxt = S_FALL;
                        end else begin
                            vel_nxt = vel - GR;
                        end
                    end
                    S_FALL: begin
                        if (fall_sum >= {1'b0, GY}) begin
                            ypos_nxt  = GY;
                            vel_nxt   = 4'd0;
                            state_nxt = S_GROUND;
                            land_nxt  = 1'b1;
                        end else begin
                            ypos_nxt = fall_sum[5:0];
                            vel_nxt  = (vel_inc > {1'b0, MFV}) ? MFV : vel_inc[3:0];
                        end
                    end
                    default: ;
                endcase
            end
            // a press coinciding with a tick is only seen by the following tick
            if (jump_rise) jump_req_nxt = 1'b1;
        end
        airborne_nxt = (state_nxt == S_RISE) || (state_nxt == S_FALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_GROUND;
            o_ypos     <= GY;
            vel        <= 4'd0;
            jump_req   <= 1'b0;
            o_airborne <= 1'b0;
            o_land     <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_ypos     <= ypos_nxt;
            vel        <= vel_nxt;
            jump_req   <= jump_req_nxt;
            o_airborne <= airborne_nxt;
            o_land     <= land_nxt;
        end
    end

endmodule

// File: tb/tb_dino_player_ctrl.sv
// Bench for dino_player_ctrl: two instances (default jump and JUMP_VEL=15) checked
// each cycle against a signed-velocity physics model, plus literal trajectory checks.
module tb_dino_player_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_frame_tick = 1'b0, i_jump = 1'b0, i_game_over = 1'b0, i_restart = 1'b0;
    logic [5:0] ypos_a, ypos_b;
    logic       air_a, air_b, land_a, land_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dino_player_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .i_frame_tick(i_frame_tick), .i_jump(i_jump),
        .i_game_over(i_game_over), .i_restart(i_restart),
        .o_ypos(ypos_a), .o_airborne(air_a), .o_land(land_a)
    );

    dino_player_ctrl #(.JUMP_VEL(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_frame_tick(i_frame_tick), .i_jump(i_jump),
        .i_game_over(i_game_over), .i_restart(i_restart),
        .o_ypos(ypos_b), .o_airborne(air_b), .o_land(land_b)
    );

    // ---------------- behavioural model ----------------
    localparam int GY = 40;
    localparam int G  = 1;
    localparam int MF = 7;
    int jv[2] = '{6, 15};

    int m_y[2];
    int m_v[2];          // signed: negative means moving up
    bit m_air[2], m_dead[2], m_land[2], m_req[2];
    bit jh[$];           // button samples, newest first

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_y[k] = GY; m_v[k] = 0; m_air[k] = 0; m_dead[k] = 0; m_land[k] = 0; m_req[k] = 0;
        end
        jh = '{0, 0, 0, 0};
    endtask

    task automatic model_step(input int k, input bit rise);
        bit old;
        m_land[k] = 0;
        if (i_game_over) begin
            m_dead[k] = 1;
            m_req[k]  = 0;
        end else if (m_dead[k]) begin
            if (i_restart) begin
                m_dead[k] = 0; m_y[k] = GY; m_v[k] = 0; m_air[k] = 0; m_req[k] = 0;
            end
        end else begin
            old = m_req[k];
            if (i_frame_tick) begin
                if (!m_air[k]) begin
                    if (old) begin
                        m_air[k] = 1; m_v[k] = -jv[k]; m_req[k] = 0;
                    end
                end else if (m_v[k] < 0) begin
                    m_y[k] = (m_y[k] + m_v[k] < 0) ? 0 : m_y[k] + m_v[k];
                    m_v[k] = (m_v[k] + G >= 0) ? 0 : m_v[k] + G;
                end else if (m_y[k] + m_v[k] >= GY) begin
                    m_y[k] = GY; m_v[k] = 0; m_air[k] = 0; m_land[k] = 1;
                end else begin
                    m_y[k] = m_y[k] + m_v[k];
                    m_v[k] = (m_v[k] + G > MF) ? MF : m_v[k] + G;
                end
            end
            if (rise) m_req[k] = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit rise;
            jh.push_front(i_jump);
            if (jh.size() > 4) void'(jh.pop_back());
            rise = jh[2] && !jh[3];
            model_step(0, rise);
            model_step(1, rise);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_ypos", ypos_a, m_y[0]);
        chk("a_air", air_a, (m_air[0] && !m_dead[0]) ? 1 : 0);
        chk("a_land", land_a, m_land[0]);
        chk("b_ypos", ypos_b, m_y[1]);
        chk("b_air", air_b, (m_air[1] && !m_dead[1]) ? 1 : 0);
        chk("b_land", land_b, m_land[1]);
    end

    // ---------------- stimulus ----------------
    int arc[12] = '{34, 29, 25, 22, 20, 19, 19, 20, 22, 25, 29, 34};
    int ceil_b[4] = '{25, 11, 0, 0};

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        step(2);
        i_frame_tick = 1'b1;
        @(negedge clk);
        i_frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        step(2);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic takeoff();
        i_jump = 1'b1;
        step(4);
        do_tick();
        chk("takeoff_air", air_a, 1);
        chk("takeoff_ypos", ypos_a, 40);
    endtask

    // ticks T1..T13 of one arc; optional press at tick jump_at, ceiling checks on dut_b
    task automatic run_arc(input int jump_at, input bit chk_b);
        for (int i = 0; i < 12; i++) begin
            do_tick();
            chk("arc_ypos", ypos_a, arc[i]);
            if (chk_b && i < 4) chk("ceil_ypos", ypos_b, ceil_b[i]);
            if (i + 1 == jump_at) i_jump = 1'b1;
        end
        do_tick();
        chk("land_ypos", ypos_a, 40);
        chk("land_pulse", land_a, 1);
        chk("land_air", air_a, 0);
        step(1);
        chk("land_pulse_end", land_a, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step(3);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // idle ground
        repeat (5) begin
            do_tick();
            chk("idle_ypos", ypos_a, 40);
            chk("idle_air", air_a, 0);
            chk("idle_land", land_a, 0);
        end

        // single jump, with JUMP_VEL=15 ceiling clamp on the second instance
        takeoff();
        i_jump = 1'b0;
        run_arc(0, 1'b1);

        // buffered jump pressed at the apex and then held
        do_reset();
        takeoff();
        i_jump = 1'b0;
        run_arc(6, 1'b0);
        do_tick();
        chk("buf_takeoff_air", air_a, 1);
        chk("buf_takeoff_ypos", ypos_a, 40);
        run_arc(0, 1'b0);
        do_tick();
        chk("held_no_rejump", air_a, 0);
        i_jump = 1'b0;

        // game over mid-fall, then restart
        do_reset();
        takeoff();
        i_jump = 1'b0;
        repeat (9) do_tick();
        chk("fall_ypos", ypos_a, 22);
        i_game_over = 1'b1;
        step(1);
        i_game_over = 1'b0;
        chk("dead_air", air_a, 0);
        repeat (10) begin
            i_jump = ~i_jump;
            do_tick();
            chk("dead_hold", ypos_a, 22);
        end
        step(4);
        i_restart = 1'b1;
        step(1);
        i_restart = 1'b0;
        chk("restart_ypos", ypos_a, 40);
        chk("restart_air", air_a, 0);
        do_tick();
        chk("restart_idle", air_a, 0);

        // asynchronous reset mid-rise
        do_reset();
        takeoff();
        i_jump = 1'b0;
        do_tick();
        chk("rise_ypos", ypos_a, 34);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ypos", ypos_a, 40);
        chk("async_air", air_a, 0);
        chk("async_ypos_b", ypos_b, 40);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            do_tick();
            chk("post_rst_air", air_a, 0);
            chk("post_rst_ypos", ypos_a, 40);
        end

        // randomized traffic
        do_reset();
        repeat (20000) begin
            @(negedge clk);
            i_frame_tick = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) i_jump = ~i_jump;
            i_game_over = ($urandom_range(0, 399) == 0);
            i_restart = ($urandom_range(0, 29) == 0);
        end
        @(negedge clk);
        i_frame_tick = 1'b0; i_game_over = 1'b0; i_restart = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
